mask_region_counter: RTL and testbench



---
 rtl/mask_region_counter_pkg.sv | 19 +
 rtl/mask_region_sat_cnt.sv | 48 ++++
 rtl/mask_region_counter.sv | 158 +++++++++++++++
 tb/tb_mask_region_counter.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_region_counter_pkg.sv
// Shared types and constants for the mask region counter.
// Holds the FSM state enums, default sizes and the region-index width.
package mask_region_counter_pkg;

    localparam int N_REGIONS_DEF = 11;
    localparam int CNT_W_DEF     = 16;
    localparam int REGION_W      = 4;

    typedef enum logic {
        IDLE,
        ACCUM
    } acc_state_t;

    typedef enum logic {
        EMPTY,
        DRAIN
    } out_state_t;

endpackage

// File: rtl/mask_region_sat_cnt.sv
// One saturating per-region counter with load/clear and a sticky sat flag.
// Ports: clk, rst_n, load (count <= inc), clear (count <= 0), inc,
//        count/sat (current), next_count/next_sat (current + inc, saturated).
module mask_region_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic [CNT_W-1:0] next_count,
    output logic             next_sat
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] load_count;

    always_comb begin
        next_count = count;
        if (inc && (count != MAX)) begin
            next_count = count + 1'b1;
        end
        next_sat   = sat | (next_count == MAX);
        load_count = CNT_W'(inc);
    end

    // load wins over clear: a frame_start pixel belongs to the new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (load) begin
            count <= load_count;
            sat   <= (load_count == MAX);
        end else if (clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else begin
            count <= next_count;
            sat   <= next_sat;
        end
    end

endmodule

// File: rtl/mask_region_counter.sv
// Counts foreground pixels per mask region over a frame, snapshots at
// frame_end and streams one region per beat over valid/ready.
// Inputs: clk, rst_n, tv_x, tv_y, pix_valid, pix_fg, mask, frame_start,
//         frame_end, out_ready.
// Outputs: out_valid, out_region, out_count, out_sat, out_last, frame_drop.
// Optional macro MASK_REGION_WINDOW_EN restricts counting to a pixel window.
module mask_region_counter
    import mask_region_counter_pkg::*;
#(
    parameter int         N_REGIONS = N_REGIONS_DEF,
    parameter int         CNT_W     = CNT_W_DEF,
    parameter logic [9:0] WIN_X0    = 10'd0,
    parameter logic [9:0] WIN_X1    = 10'd639,
    parameter logic [9:0] WIN_Y0    = 10'd0,
    parameter logic [9:0] WIN_Y1    = 10'd479
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           tv_x,
    input  logic [9:0]           tv_y,
    input  logic                 pix_valid,
    input  logic                 pix_fg,
    input  logic [N_REGIONS-1:0] mask,
    input  logic                 frame_start,
    input  logic                 frame_end,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REGION_W-1:0]  out_region,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_sat,
    output logic                 out_last,
    output logic                 frame_drop
);

    acc_state_t acc_state, acc_next;
    out_state_t out_state, out_next;

    logic                 armed;
    logic                 in_win;
    logic                 count_en;
    logic                 pix_hit;
    logic [N_REGIONS-1:0] inc;

    logic [CNT_W-1:0]     live_cnt [N_REGIONS];
    logic [CNT_W-1:0]     live_nxt [N_REGIONS];
    logic [N_REGIONS-1:0] live_sat;
    logic [N_REGIONS-1:0] live_nsat;

    logic [CNT_W-1:0]     snap_cnt [N_REGIONS];
    logic [N_REGIONS-1:0] snap_sat;

    logic [REGION_W-1:0]  idx;
    logic                 draining;
    logic                 is_last;
    logic                 accept;
    logic                 last_done;
    logic                 take_snap;

`ifdef MASK_REGION_WINDOW_EN
    assign in_win = (tv_x >= WIN_X0) && (tv_x <= WIN_X1) &&
                    (tv_y >= WIN_Y0) && (tv_y <= WIN_Y1);
`else
    logic unused_win;
    assign in_win     = 1'b1;
    assign unused_win = ^{tv_x, tv_y, WIN_X0, WIN_X1, WIN_Y0, WIN_Y1};
`endif

    // armed drops at frame_end so pixels between frames are ignored
    assign count_en = frame_start | ((acc_state == ACCUM) & armed);
    assign pix_hit  = pix_valid & pix_fg & in_win & count_en;
    assign inc      = mask & {N_REGIONS{pix_hit}};

    for (genvar i = 0; i < N_REGIONS; i++) begin : g_cnt
        mask_region_sat_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (frame_start),
            .clear     (frame_end),
            .inc       (inc[i]),
            .count     (live_cnt[i]),
            .sat       (live_sat[i]),
            .next_count(live_nxt[i]),
            .next_sat  (live_nsat[i])
        );
    end

    always_comb begin
        acc_next = acc_state;
        unique case (acc_state)
            IDLE:    if (frame_start) acc_next = ACCUM;
            ACCUM:   acc_next = ACCUM;
            default: acc_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_state <= IDLE;
            armed     <= 1'b0;
        end else begin
            acc_state <= acc_next;
            if (frame_start) begin
                armed <= 1'b1;
            end else if (frame_end) begin
                armed <= 1'b0;
            end
        end
    end

    assign draining  = (out_state == DRAIN);
    assign is_last   = (idx == REGION_W'(N_REGIONS - 1));
    assign accept    = draining & out_ready;
    assign last_done = accept & is_last;
    assign take_snap = frame_end & (~draining | last_done);

    always_comb begin
        out_next = out_state;
        unique case (out_state)
            EMPTY:   if (frame_end) out_next = DRAIN;
            DRAIN:   if (last_done) out_next = frame_end ? DRAIN : EMPTY;
            default: out_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state  <= EMPTY;
            idx        <= '0;
            frame_drop <= 1'b0;
            snap_sat   <= '0;
            for (int i = 0; i < N_REGIONS; i++) begin
                snap_cnt[i] <= '0;
            end
        end else begin
            out_state  <= out_next;
            frame_drop <= frame_end & draining & ~last_done;
            if (accept) begin
                idx <= is_last ? '0 : idx + 1'b1;
            end
            // a coincident frame_start pixel goes to the new frame
            if (take_snap) begin
                for (int i = 0; i < N_REGIONS; i++) begin
                    snap_cnt[i] <= frame_start ? live_cnt[i] : live_nxt[i];
                    snap_sat[i] <= frame_start ? live_sat[i] : live_nsat[i];
                end
            end
        end
    end

    assign out_valid  = draining;
    assign out_region = draining ? idx : '0;
    assign out_count  = draining ? snap_cnt[idx] : '0;
    assign out_sat    = draining & snap_sat[idx];
    assign out_last   = draining & is_last;

endmodule

// File: tb/tb_mask_region_counter.sv
// Scoreboard bench for mask_region_counter: expected beats are queued at
// frame_end and compared against beats captured on accepted transfers.
`timescale 1ns/1ps
module tb_mask_region_counter;

    localparam int N = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  tv_x, tv_y;
    logic        pix_valid, pix_fg;
    logic [10:0] mask;
    logic        frame_start, frame_end;
    logic        out_ready, ready4;

    logic        out_valid, out_sat, out_last, frame_drop;
    logic [3:0]  out_region;
    logic [15:0] out_count;

    logic        v4, s4, l4, d4;
    logic [3:0]  r4;
    logic [3:0]  c4;

    typedef struct packed {
        logic [3:0]  region;
        logic [15:0] count;
        logic        sat;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t exp4_q[$];
    beat_t got4_q[$];

    int compared   = 0;
    int mismatched = 0;
    int model[N];

    always #5 clk = ~clk;

    mask_region_counter #(
        .N_REGIONS(N), .CNT_W(16),
        .WIN_X0(10'd10), .WIN_X1(10'd19), .WIN_Y0(10'd0), .WIN_Y1(10'd479)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tv_x(tv_x), .tv_y(tv_y),
        .pix_valid(pix_valid), .pix_fg(pix_fg), .mask(mask),
        .frame_start(frame_start), .frame_end(frame_end),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_region(out_region), .out_count(out_count),
        .out_sat(out_sat), .out_last(out_last), .frame_drop(frame_drop)
    );

    mask_region_counter #(
        .N_REGIONS(N), .CNT_W(4),
        .WIN_X0(10'd10), .WIN_X1(10'd19), .WIN_Y0(10'd0), .WIN_Y1(10'd479)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .tv_x(tv_x), .tv_y(tv_y),
        .pix_valid(pix_valid), .pix_fg(pix_fg), .mask(mask),
        .frame_start(frame_start), .frame_end(frame_end),
        .out_valid(v4), .out_ready(ready4),
        .out_region(r4), .out_count(c4),
        .out_sat(s4), .out_last(l4), .frame_drop(d4)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready)
                got_q.push_back({out_region, out_count, out_sat, out_last});
            if (v4 && ready4)
                got4_q.push_back({r4, 12'd0, c4, s4, l4});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input bit fs, input bit fe, input bit vld,
                         input bit fg, input logic [10:0] m,
                         input logic [9:0] x);
        frame_start = fs;
        frame_end   = fe;
        pix_valid   = vld;
        pix_fg      = fg;
        mask        = m;
        tv_x        = x;
        cyc();
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pix_valid   = 1'b0;
        pix_fg      = 1'b0;
        mask        = '0;
        tv_x        = 10'd15;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) model[i] = 0;
    endtask

    task automatic push_frame();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b.region = 4'(i);
            b.count  = (model[i] > 65535) ? 16'hFFFF : 16'(model[i]);
            b.sat    = (model[i] >= 65535);
            b.last   = (i == N - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_beats(input int n, output bit ok);
        for (int i = 0; i < 400 && got_q.size() < n; i++) @(posedge clk);
        ok = (got_q.size() >= n);
        repeat (2) cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({out_valid, out_region, out_count, out_sat, out_last,
             frame_drop} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got v=%b r=%0d c=%0d, required 0",
                     out_valid, out_region, out_count);
        end
        cyc();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({out_valid, out_count, frame_drop} !== '0) begin
            mismatched++;
            $display("FAIL post_reset_idle: got v=%b c=%0d d=%b, required 0",
                     out_valid, out_count, frame_drop);
        end
        cyc();
    endtask

    task automatic test_single_region();
        bit ok;
        beat_t e, g;
        clear_model();
        model[0] = 100;
        pixel(1, 0, 1, 1, 11'h001, 10'd15);
        for (int k = 1; k < 100; k++) pixel(0, 0, 1, 1, 11'h001, 10'd15);
        frame_end = 1'b1;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL valid_at_frame_end: got %b, required 0", out_valid);
        end
        cyc();
        frame_end = 1'b0;
        compared++;
        if (out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL first_valid_latency: got %b, required 1", out_valid);
        end
        push_frame();
        wait_beats(11, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL single_timeout: got %0d beats, required 11",
                     got_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL single_beat: got r=%0d c=%0d s=%b l=%b, required r=%0d c=%0d s=%b l=%b",
                         g.region, g.count, g.sat, g.last,
                         e.region, e.count, e.sat, e.last);
            end
        end
    endtask

    task automatic test_all_regions();
        bit ok;
        beat_t e, g;
        clear_model();
        for (int i = 0; i < N; i++) model[i] = 50;
        for (int k = 0; k < 50; k++) begin
            pixel(k == 0, 0, 1, 1, 11'h7FF, 10'd15);
            if (k < 30) pixel(0, 0, 1, 0, 11'h7FF, 10'd15);
            if (k < 10) pixel(0, 0, 0, 1, 11'h7FF, 10'd15);
        end
        pixel(0, 1, 0, 0, 11'h000, 10'd15);
        push_frame();
        wait_beats(11, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL all_timeout: got %0d beats, required 11",
                     got_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL all_beat: got r=%0d c=%0d s=%b, required r=%0d c=%0d s=%b",
                         g.region, g.count, g.sat, e.region, e.count, e.sat);
            end
        end
    endtask

    task automatic test_saturation();
        bit ok;
        beat_t e, g;
        got4_q.delete();
        clear_model();
        model[3] = 20;
        for (int k = 0; k < 20; k++) pixel(k == 0, 0, 1, 1, 11'h008, 10'd15);
        pixel(0, 1, 0, 0, 11'h000, 10'd15);
        push_frame();
        for (int i = 0; i < N; i++) begin
            e.region = 4'(i);
            e.count  = (i == 3) ? 16'd15 : 16'd0;
            e.sat    = (i == 3);
            e.last   = (i == N - 1);
            exp4_q.push_back(e);
        end
        wait_beats(11, ok);
        for (int i = 0; i < 100 && got4_q.size() < 11; i++) cyc();
        compared++;
        if (!ok || got4_q.size() != 11) begin
            mismatched++;
            $display("FAIL sat_timeout: got %0d/%0d beats, required 11",
                     got_q.size(), got4_q.size());
        end
        while (exp4_q.size() > 0) begin
            e = exp4_q.pop_front();
            g = (got4_q.size() > 0) ? got4_q.pop_front() : '0;
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL sat4_beat: got r=%0d c=%0d s=%b, required r=%0d c=%0d s=%b",
                         g.region, g.count, g.sat, e.region, e.count, e.sat);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL sat16_beat: got r=%0d c=%0d s=%b, required r=%0d c=%0d s=%b",
                         g.region, g.count, g.sat, e.region, e.count, e.sat);
            end
        end
    endtask

    task automatic test_stall();
        beat_t e, g, held_v;
        bit held;
        int n_got;
        clear_model();
        for (int k = 0; k < 33; k++) begin
            pixel(k == 0, 0, 1, 1, 11'(k), 10'd15);
            for (int i = 0; i < N; i++) if (k[i]) model[i]++;
        end
        pixel(0, 1, 0, 0, 11'h000, 10'd15);
        out_ready = 1'b0;
        push_frame();
        held = 1'b0;
        held_v = '0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (held) begin
                compared++;
                if ({out_region, out_count, out_sat, out_last} !== held_v ||
                    out_valid !== 1'b1) begin
                    mismatched++;
                    $display("FAIL stall_stable: got r=%0d c=%0d v=%b, required r=%0d c=%0d v=1",
                             out_region, out_count, out_valid,
                             held_v.region, held_v.count);
                end
            end
            held   = out_valid && !out_ready;
            held_v = {out_region, out_count, out_sat, out_last};
            if (got_q.size() >= 11 && !out_valid) break;
            cyc();
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        cyc();
        n_got = got_q.size();
        compared++;
        if (n_got != 11) begin
            mismatched++;
            $display("FAIL stall_transfers: got %0d, required 11", n_got);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL stall_beat: got r=%0d c=%0d, required r=%0d c=%0d",
                         g.region, g.count, e.region, e.count);
            end
        end
        got_q.delete();
    endtask

    task automatic test_drop();
        bit ok;
        beat_t e, g;
        clear_model();
        model[4]  = 7;
        model[10] = 5;
        for (int k = 0; k < 7; k++) pixel(k == 0, 0, 1, 1, 11'h010, 10'd15);
        for (int k = 0; k < 5; k++) pixel(0, 0, 1, 1, 11'h400, 10'd15);
        pixel(0, 1, 0, 0, 11'h000, 10'd15);
        push_frame();
        for (int i = 0; i < 50 && got_q.size() < 4; i++) cyc();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) pixel(k == 0, 0, 1, 1, 11'h7FF, 10'd15);
        pixel(0, 1, 1, 1, 11'h7FF, 10'd15);
        compared++;
        if (frame_drop !== 1'b1) begin
            mismatched++;
            $display("FAIL drop_pulse: got %b, required 1", frame_drop);
        end
        compared++;
        if (out_valid !== 1'b1 || out_region !== 4'd4) begin
            mismatched++;
            $display("FAIL drop_drain_kept: got v=%b r=%0d, required v=1 r=4",
                     out_valid, out_region);
        end
        cyc();
        compared++;
        if (frame_drop !== 1'b0) begin
            mismatched++;
            $display("FAIL drop_one_cycle: got %b, required 0", frame_drop);
        end
        out_ready = 1'b1;
        wait_beats(11, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL drop_timeout: got %0d beats, required 11",
                     got_q.size());
        end
        clear_model();
        model[1] = 9;
        for (int k = 0; k < 9; k++) pixel(k == 0, 0, 1, 1, 11'h002, 10'd15);
        pixel(0, 1, 0, 0, 11'h000, 10'd15);
        push_frame();
        wait_beats(22, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL next_frame_timeout: got %0d beats, required 22",
                     got_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL drop_beat: got r=%0d c=%0d l=%b, required r=%0d c=%0d l=%b",
                         g.region, g.count, g.last, e.region, e.count, e.last);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        beat_t e, g;
        clear_model();
        model[8] = 4;
        for (int k = 0; k < 4; k++) pixel(k == 0, 0, 1, 1, 11'h100, 10'd15);
        pixel(0, 1, 0, 0, 11'h000, 10'd15);
        push_frame();
        clear_model();
        model[0] = 10;
        for (int k = 0; k < 10; k++) pixel(k == 0, 0, 1, 1, 11'h001, 10'd15);
        pixel(0, 1, 0, 0, 11'h000, 10'd15);
        push_frame();
        compared++;
        if (frame_drop !== 1'b0 || out_valid !== 1'b1 ||
            out_region !== 4'd0) begin
            mismatched++;
            $display("FAIL b2b_restart: got d=%b v=%b r=%0d, required d=0 v=1 r=0",
                     frame_drop, out_valid, out_region);
        end
        wait_beats(22, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL b2b_timeout: got %0d beats, required 22",
                     got_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL b2b_beat: got r=%0d c=%0d, required r=%0d c=%0d",
                         g.region, g.count, e.region, e.count);
            end
        end
    endtask

    task automatic test_start_end_same();
        bit ok;
        beat_t e, g;
        clear_model();
        model[5] = 6;
        for (int k = 0; k < 6; k++) pixel(k == 0, 0, 1, 1, 11'h020, 10'd15);
        pixel(1, 1, 1, 1, 11'h020, 10'd15);
        push_frame();
        for (int k = 0; k < 3; k++) pixel(0, 0, 1, 1, 11'h020, 10'd15);
        wait_beats(11, ok);
        clear_model();
        model[5] = 4;
        pixel(0, 1, 0, 0, 11'h000, 10'd15);
        push_frame();
        wait_beats(22, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL same_cycle_timeout: got %0d beats, required 22",
                     got_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL same_cycle_beat: got r=%0d c=%0d, required r=%0d c=%0d",
                         g.region, g.count, e.region, e.count);
            end
        end
    endtask

    task automatic test_window();
        bit ok;
        beat_t e, g;
        clear_model();
`ifdef MASK_REGION_WINDOW_EN
        model[1] = 10;
`else
        model[1] = 40;
`endif
        tv_y = 10'd5;
        for (int k = 0; k < 40; k++) pixel(k == 0, 0, 1, 1, 11'h002, 10'(k));
        pixel(0, 1, 0, 0, 11'h000, 10'd15);
        push_frame();
        wait_beats(11, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL window_timeout: got %0d beats, required 11",
                     got_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL window_beat: got r=%0d c=%0d, required r=%0d c=%0d",
                         g.region, g.count, e.region, e.count);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int k = 0; k < 5; k++) pixel(k == 0, 0, 1, 1, 11'h7FF, 10'd15);
        pixel(0, 1, 0, 0, 11'h000, 10'd15);
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || out_count !== 16'd0) begin
            mismatched++;
            $display("FAIL async_reset_drop: got v=%b c=%0d, required 0",
                     out_valid, out_count);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        got_q.delete();
        got4_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        tv_x        = 10'd15;
        tv_y        = 10'd0;
        pix_valid   = 1'b0;
        pix_fg      = 1'b0;
        mask        = '0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        out_ready   = 1'b1;
        ready4      = 1'b1;
        test_reset();
        test_single_region();
        test_all_regions();
        test_saturation();
        test_stall();
        test_drop();
        test_back_to_back();
        test_start_end_same();
        test_window();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
